// File: rtl/pipe_if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface pipe_if_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        valid_IF;
  logic [31:0] inst_IF;
  logic [31:0] npc_IF;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, valid_IF, inst_IF, npc_IF
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, valid_IF, inst_IF, npc_IF
  );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, synchronous ROM requests and a small prefetch FIFO.
// Define PIPE_IF_BYPASS_EN to forward a returning word straight to the outputs when the FIFO is empty.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_if_stage_if.master bus
);

  localparam int PTR_W = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(FBUF_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(FBUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FBUF_DEPTH - 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      inst_mem_q [FBUF_DEPTH];
  logic [31:0]      inst_mem_d [FBUF_DEPTH];
  logic [31:0]      npc_mem_q  [FBUF_DEPTH];
  logic [31:0]      npc_mem_d  [FBUF_DEPTH];

  logic             head_valid;
  logic             bypass;
  logic             out_valid;
  logic [31:0]      out_inst;
  logic [31:0]      out_npc;
  logic             pop;
  logic             fifo_pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head_valid = (cnt_q != '0);
`ifdef PIPE_IF_BYPASS_EN
    bypass = !head_valid && inflight_q && !bus.redirect_i;
`else
    bypass = 1'b0;
`endif
    out_valid = head_valid | bypass;
    out_inst  = '0;
    out_npc   = '0;
    if (head_valid) begin
      out_inst = inst_mem_q[rd_ptr_q];
      out_npc  = npc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_inst = bus.imem_rdata_i;
      out_npc  = tag_q;
    end

    pop      = out_valid && !bus.stall_i && !bus.redirect_i;
    fifo_pop = pop && head_valid;
    // A bypassed word that is consumed this cycle never enters the FIFO.
    push      = inflight_q && !bus.redirect_i && !(bypass && pop);
    occupancy = (CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    // Requests are suppressed while reset is asserted so the ROM sees no strobe.
    issue     = rst_n && (bus.redirect_i || (occupancy < DEPTH_W));
  end

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inst_mem_d = inst_mem_q;
    npc_mem_d  = npc_mem_q;

    if (bus.redirect_i) begin
      pc_d       = bus.redirect_pc_i + 32'd4;
      tag_d      = bus.redirect_pc_i + 32'd4;
      inflight_d = 1'b1;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = bus.imem_rdata_i;
        npc_mem_d[wr_ptr_q]  = tag_q;
        wr_ptr_d             = next_ptr(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(fifo_pop);
      if (issue) begin
        pc_d       = pc_q + 32'd4;
        tag_d      = pc_q + 32'd4;
        inflight_d = 1'b1;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FBUF_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        npc_mem_q[i]  <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inst_mem_q <= inst_mem_d;
      npc_mem_q  <= npc_mem_d;
    end
  end

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = bus.redirect_i ? bus.redirect_pc_i : pc_q;
  assign bus.valid_IF    = out_valid;
  assign bus.inst_IF     = out_inst;
  assign bus.npc_IF      = out_npc;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: a queue-based fetch model driven by
// directed scenarios plus randomized stall/redirect traffic against a ROM with ROM[i]=i+1.
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef PIPE_IF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] npc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_if_stage_if bus ();

  pipe_if_stage #(.RESET_PC(RESET_PC), .FBUF_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  // Synchronous ROM: data appears the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_rdata_i <= rom_word(bus.imem_addr_o);
    else                bus.imem_rdata_i <= $urandom;
  end

  entry_t      q[$];
  logic [31:0] m_pc, m_tag;
  bit          m_infl;
  bit          e_pop, e_issue, e_byp;
  bit          cur_redir;
  logic [31:0] cur_rpc;
  logic [97:0] obs, exp_v;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_tag  = '0;
    m_infl = 0;
  endtask

  task automatic cycle_begin(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
    entry_t head;
    bit     valid;
    int     occ;
    @(negedge clk);
    rst_n             = rst;
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    cur_redir         = rd;
    cur_rpc           = rpc;
    if (!rst) model_reset();
    e_byp = 0;
`ifdef PIPE_IF_BYPASS_EN
    e_byp = (q.size() == 0) && m_infl && !rd;
`endif
    valid = (q.size() != 0) || e_byp;
    head  = '0;
    if (q.size() != 0) head = q[0];
    else if (e_byp)    head = {rom_word(m_tag - 32'd4), m_tag};
    e_pop   = valid && !st && !rd;
    occ     = q.size() + int'(m_infl) - int'(e_pop);
    e_issue = rst && (rd || occ < DEPTH);
    exp_v   = {e_issue, e_issue ? (rd ? rpc : m_pc) : 32'h0, valid,
               valid ? head.inst : 32'h0, valid ? head.npc : 32'h0};
    #1;
    obs = {bus.imem_req_o, bus.imem_req_o ? bus.imem_addr_o : 32'h0,
           bus.valid_IF, bus.inst_IF, bus.npc_IF};
  endtask

  task automatic cycle_end();
    if (rst_n) begin
      if (cur_redir) begin
        q.delete();
        m_pc   = cur_rpc + 32'd4;
        m_tag  = cur_rpc + 32'd4;
        m_infl = 1;
      end else begin
        if (e_pop && !e_byp) void'(q.pop_front());
        if (m_infl && !(e_byp && e_pop)) q.push_back({rom_word(m_tag - 32'd4), m_tag});
        if (e_issue) begin
          m_tag  = m_pc + 32'd4;
          m_pc   = m_pc + 32'd4;
          m_infl = 1;
        end else begin
          m_infl = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0;
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle_begin(0, 0, 0, 32'h0);
      if (obs !== 98'h0) begin
        n_err++;
        $display("[TB] FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, 98'h0);
      end
      n_cmp++;
      cycle_end();
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      cycle_begin(1, 0, 0, 32'h0);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      if (i == LAT) begin
        if (obs[64:0] !== {1'b1, 32'd1, 32'd4}) begin
          n_err++;
          $display("[TB] FAIL first_valid cyc=%0d got=%h exp=%h", cyc, obs[64:0], {1'b1, 32'd1, 32'd4});
        end
        n_cmp++;
      end
      cycle_end();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 7; i++) begin
      cycle_begin(1, (i < 4), 0, 32'h0);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      if (i == 3 && obs[97] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL stall_req_drop cyc=%0d got=%b exp=0", cyc, obs[97]);
      end
      if (i == 3) n_cmp++;
      cycle_end();
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 9; i++) begin
      cycle_begin(1, (i < 3), (i == 3), 32'h40);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL redirect cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
`ifndef PIPE_IF_BYPASS_EN
      if (i == 4) begin
        if (obs[64] !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL redirect_bubble cyc=%0d got=%b exp=0", cyc, obs[64]);
        end
        n_cmp++;
      end
`endif
      if (i == 3 + LAT) begin
        if (obs[64:0] !== {1'b1, 32'd17, 32'h44}) begin
          n_err++;
          $display("[TB] FAIL redirect_target cyc=%0d got=%h exp=%h", cyc, obs[64:0], {1'b1, 32'd17, 32'h44});
        end
        n_cmp++;
      end
      cycle_end();
    end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 6; i++) begin
      cycle_begin(1, 1, (i == 0), 32'h80);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL redir_stall cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      if (i >= LAT) begin
        if (obs[64:0] !== {1'b1, 32'd33, 32'h84}) begin
          n_err++;
          $display("[TB] FAIL redir_stall_hold cyc=%0d got=%h exp=%h", cyc, obs[64:0], {1'b1, 32'd33, 32'h84});
        end
        n_cmp++;
      end
      cycle_end();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cycle_begin(1, 0, (i < 2), (i == 0) ? 32'h100 : 32'h200);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      if (i == 1 + LAT) begin
        if (obs[64:0] !== {1'b1, 32'd129, 32'h204}) begin
          n_err++;
          $display("[TB] FAIL last_redirect_wins cyc=%0d got=%h exp=%h", cyc, obs[64:0], {1'b1, 32'd129, 32'h204});
        end
        n_cmp++;
      end
      cycle_end();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      cycle_begin(1, 0, 0, 32'h0);
      cycle_end();
    end
    #2 rst_n = 0;
    #1;
    if ({bus.imem_req_o, bus.valid_IF, bus.inst_IF, bus.npc_IF} !== 66'h0) begin
      n_err++;
      $display("[TB] FAIL async_reset got=%h exp=0", {bus.imem_req_o, bus.valid_IF, bus.inst_IF, bus.npc_IF});
    end
    n_cmp++;
    model_reset();
    cycle_begin(0, 0, 0, 32'h0);
    cycle_end();
    for (int i = 0; i < 5; i++) begin
      cycle_begin(1, 0, 0, 32'h0);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      if (i == LAT) begin
        if (obs[64:0] !== {1'b1, 32'd1, 32'd4}) begin
          n_err++;
          $display("[TB] FAIL refetch_reset_pc cyc=%0d got=%h exp=%h", cyc, obs[64:0], {1'b1, 32'd1, 32'd4});
        end
        n_cmp++;
      end
      cycle_end();
    end
  endtask

  task automatic test_random();
    bit          st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cycle_begin(1, st, rd, rpc);
      if (obs !== exp_v) begin
        n_err++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
      n_cmp++;
      cycle_end();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
